mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum BUSY cycles to wait for mem_done before the stage faults.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low; sampled only on the rising edge of clk.
REQ-004 ALUO_EXMEM  input  16  ALU result; this is the memory address for loads and stores.
REQ-005 Rd2_EXMEM  input  16  store data.
REQ-006 WrR_EXMEM  input  3  destination register.
REQ-007 RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, Dump_EXMEM  input  1 each  control bits from EX/MEM.
REQ-008 takeBranch_EXMEM  input  1, PCS_EXMEM  input  16  resolved branch flag and next PC.
REQ-009 mem_req  output  1  one-cycle request strobe to data memory.
REQ-010 mem_wr  output  1  1 = write, 0 = read; valid while mem_req is high or state is BUSY.
REQ-011 mem_addr  output  16, mem_wdata  output  16  access address and write data.
REQ-012 mem_rdata  input  16, mem_done  input  1  read data and completion strobe from memory.
REQ-013 stall  output  1  holds all upstream stages.
REQ-014 ALUO_MEMWB, MemOut_MEMWB  output  16 each; WrR_MEMWB  output  3; RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB  output  1 each. These form the MEM/WB pipeline register.
REQ-015 takeBranch_out  output  1, PCS_out  output  16  combinational pass-through of takeBranch_EXMEM and PCS_EXMEM to fetch.
REQ-016 err  output  1  sticky fault flag.

Function
REQ-017 The access condition is access = MemRead_EXMEM | MemWrite_EXMEM.
REQ-018 The FSM SHALL have three states, IDLE, BUSY and ERR, plus a timeout counter wide enough to hold TIMEOUT.
REQ-019 IDLE with access and ALUO_EXMEM[0]=0 SHALL behave as follows.
- Combinationally: mem_req=1, mem_wr=MemWrite_EXMEM, mem_addr=ALUO_EXMEM, mem_wdata=Rd2_EXMEM, stall=1.
- At the next rising edge: latch addr, wdata and wr; clear the counter; go to BUSY.
REQ-020 IDLE with access and ALUO_EXMEM[0]=1 (misaligned) SHALL issue no mem_req and SHALL go to ERR at the next rising edge.
REQ-021 IDLE with no access SHALL drive stall=0, and the next edge SHALL load MEM/WB from EX/MEM with MemOut_MEMWB=16'h0000.
REQ-022 BUSY SHALL drive mem_req=0, drive the latched mem_addr, mem_wdata and mem_wr, and drive stall=1 while mem_done=0.
REQ-023 BUSY with mem_done=0 SHALL increment the counter; when the counter reaches TIMEOUT the next edge SHALL go to ERR.
REQ-024 BUSY with mem_done=1 SHALL behave as follows.
- Combinationally: stall=0.
- At the next rising edge: load MEM/WB from EX/MEM with MemOut_MEMWB=mem_rdata (16'h0000 for stores); return to IDLE.
REQ-025 Minimum access latency is 2 cycles (request cycle, then done cycle); mem_done SHALL be ignored in IDLE and ERR.
REQ-026 In every cycle with stall=1, the next edge SHALL load a bubble into MEM/WB: RegWrite_MEMWB=0, Dump_MEMWB=0, other MEM/WB fields unchanged.
REQ-027 Back-to-back accesses SHALL each take a separate IDLE->BUSY->IDLE sequence, with no overlap of requests.
REQ-028 ERR SHALL drive err=1, stall=1 and mem_req=0, and SHALL load bubbles into MEM/WB; only reset exits ERR.
REQ-029 takeBranch_out and PCS_out SHALL be ungated combinational copies of their inputs.
REQ-030 err SHALL be registered; it goes high on the edge that enters ERR.

Reset
REQ-031 With rst=0 at a rising edge, the block SHALL reset as follows.
- state=IDLE, counter=0, err=0.
- Latched addr, wdata and wr = 0.
- All MEM/WB outputs = 0.
REQ-032 Reset while in BUSY SHALL abandon the access, and any later mem_done SHALL be ignored.
REQ-033 During reset the combinational outputs SHALL follow IDLE rules with the reset state.

Verification
REQ-034 Load: ALUO=0x0010, MemRead=1, RegWrite=1, MemtoReg=1, WrR=3; mem_done=1 with rdata=0xBEEF on the 3rd cycle after the request.
-> One mem_req pulse with addr=0x0010 and wr=0; stall high 3 cycles; then MemOut_MEMWB=0xBEEF, WrR_MEMWB=3, RegWrite_MEMWB=1.
REQ-035 Store: ALUO=0x0020, Rd2=0x1234, MemWrite=1; mem_done in the cycle after the request.
-> mem_wr=1, wdata=0x1234, stall high 1 cycle, RegWrite_MEMWB=0.
REQ-036 Misaligned access: ALUO=0x0011, MemRead=1.
-> No mem_req; err=1 after one edge; stall stays 1 until rst=0.
REQ-037 Timeout: TIMEOUT=15 and mem_done held at 0.
-> err rises after 15 BUSY cycles; mem_req pulses once only.
REQ-038 Non-memory instruction: ALUO=0x00FF, RegWrite=1, WrR=5.
-> stall=0; next edge ALUO_MEMWB=0x00FF, MemOut_MEMWB=0, WrR_MEMWB=5.
REQ-039 Reset in BUSY: rst=0 for one edge, then mem_done=1.
-> State IDLE, all outputs 0, no MEM/WB update from the late mem_done.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory handshake between the MEM stage (master) and the memory (slave).
interface mem_stage_if;
  localparam int unsigned DW = 16;

  logic          mem_req;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory access per load/store, stalls until
// completion or timeout, and owns the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master mem,
  input  logic [15:0] ALUO_EXMEM,
  input  logic [15:0] Rd2_EXMEM,
  input  logic [2:0]  WrR_EXMEM,
  input  logic        RegWrite_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        MemRead_EXMEM,
  input  logic        MemWrite_EXMEM,
  input  logic        Dump_EXMEM,
  input  logic        takeBranch_EXMEM,
  input  logic [15:0] PCS_EXMEM,
  output logic        stall,
  output logic [15:0] ALUO_MEMWB,
  output logic [15:0] MemOut_MEMWB,
  output logic [2:0]  WrR_MEMWB,
  output logic        RegWrite_MEMWB,
  output logic        MemtoReg_MEMWB,
  output logic        Dump_MEMWB,
  output logic        takeBranch_out,
  output logic [15:0] PCS_out,
  output logic        err
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [DW-1:0] addr_q, wdata_q;
  logic          wr_q;
  logic          issue;
  logic          load;
  logic          use_rdata;
  logic          access;

  assign access         = MemRead_EXMEM | MemWrite_EXMEM;
  assign takeBranch_out = takeBranch_EXMEM;
  assign PCS_out        = PCS_EXMEM;

  // State, timeout counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err   <= err | (state_next == ERR);
    end
  end

  // Next state and combinational memory/stall outputs.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    issue         = 1'b0;
    load          = 1'b0;
    use_rdata     = 1'b0;
    stall         = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_wr    = wr_q;
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (!ALUO_EXMEM[0]) begin
            issue         = 1'b1;
            mem.mem_req   = 1'b1;
            mem.mem_wr    = MemWrite_EXMEM;
            mem.mem_addr  = ALUO_EXMEM;
            mem.mem_wdata = Rd2_EXMEM;
            cnt_next      = '0;
            state_next    = BUSY;
          end else begin
            state_next = ERR;
          end
        end else begin
          load = 1'b1;
        end
      end
      BUSY: begin
        if (mem.mem_done) begin
          load       = 1'b1;
          use_rdata  = !wr_q;
          state_next = IDLE;
        end else begin
          stall = 1'b1;
          // Fault once this BUSY cycle would bring the count to TIMEOUT.
          if (cnt == CW'(TIMEOUT - 1)) begin
            state_next = ERR;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        stall      = 1'b1;
        state_next = ERR;
      end
    endcase
  end

  // Latched access and MEM/WB register; stalled cycles insert a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_q           <= 1'b0;
      ALUO_MEMWB     <= '0;
      MemOut_MEMWB   <= '0;
      WrR_MEMWB      <= '0;
      RegWrite_MEMWB <= 1'b0;
      MemtoReg_MEMWB <= 1'b0;
      Dump_MEMWB     <= 1'b0;
    end else begin
      if (issue) begin
        addr_q  <= ALUO_EXMEM;
        wdata_q <= Rd2_EXMEM;
        wr_q    <= MemWrite_EXMEM;
      end
      if (load) begin
        ALUO_MEMWB     <= ALUO_EXMEM;
        MemOut_MEMWB   <= use_rdata ? mem.mem_rdata : '0;
        WrR_MEMWB      <= WrR_EXMEM;
        RegWrite_MEMWB <= RegWrite_EXMEM;
        MemtoReg_MEMWB <= MemtoReg_EXMEM;
        Dump_MEMWB     <= Dump_EXMEM;
      end else if (stall) begin
        RegWrite_MEMWB <= 1'b0;
        Dump_MEMWB     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// load/store/ALU traffic checked against an instruction-level expectation.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ALUO_EXMEM, Rd2_EXMEM, PCS_EXMEM;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM, MemtoReg_EXMEM, MemRead_EXMEM, MemWrite_EXMEM;
  logic        Dump_EXMEM, takeBranch_EXMEM;
  logic        stall, err, takeBranch_out;
  logic [15:0] ALUO_MEMWB, MemOut_MEMWB, PCS_out;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB;

  int tests = 0;
  int fails = 0;

  mem_stage_if mif ();

  mem_stage #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mem(mif),
    .ALUO_EXMEM(ALUO_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .WrR_EXMEM(WrR_EXMEM),
    .RegWrite_EXMEM(RegWrite_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .Dump_EXMEM(Dump_EXMEM), .takeBranch_EXMEM(takeBranch_EXMEM), .PCS_EXMEM(PCS_EXMEM),
    .stall(stall), .ALUO_MEMWB(ALUO_MEMWB), .MemOut_MEMWB(MemOut_MEMWB),
    .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
    .MemtoReg_MEMWB(MemtoReg_MEMWB), .Dump_MEMWB(Dump_MEMWB),
    .takeBranch_out(takeBranch_out), .PCS_out(PCS_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ALUO_EXMEM = '0; Rd2_EXMEM = '0; WrR_EXMEM = '0; PCS_EXMEM = '0;
    RegWrite_EXMEM = 0; MemtoReg_EXMEM = 0; MemRead_EXMEM = 0; MemWrite_EXMEM = 0;
    Dump_EXMEM = 0; takeBranch_EXMEM = 0;
    mif.mem_done = 0; mif.mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    tick(); tick();
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got=%0h exp=0", err); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    tests++; if (mif.mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got=%0h exp=0", mif.mem_req); end
    tests++; if (mif.mem_addr !== 16'h0 || mif.mem_wdata !== 16'h0 || mif.mem_wr !== 1'b0) begin
      fails++; $display("FAIL rst_latch got=%h/%h/%0h exp=0/0/0", mif.mem_addr, mif.mem_wdata, mif.mem_wr); end
    tests++; if ({ALUO_MEMWB, MemOut_MEMWB, WrR_MEMWB, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB} !== '0) begin
      fails++; $display("FAIL rst_memwb got=%h/%h/%0h/%0b%0b%0b exp=0", ALUO_MEMWB, MemOut_MEMWB,
                        WrR_MEMWB, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB); end
    rst = 1;
  endtask

  task automatic test_load();
    int reqs = 0;
    int stalls = 0;
    clear_inputs();
    ALUO_EXMEM = 16'h0010; MemRead_EXMEM = 1; RegWrite_EXMEM = 1; MemtoReg_EXMEM = 1; WrR_EXMEM = 3'd3;
    #1;
    tests++; if (mif.mem_addr !== 16'h0010 || mif.mem_wr !== 1'b0) begin
      fails++; $display("FAIL load_req_addr got=%h wr=%0h exp=0010 wr=0", mif.mem_addr, mif.mem_wr); end
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin mif.mem_done = 1; mif.mem_rdata = 16'hBEEF; end
      #1;
      if (mif.mem_req === 1'b1) reqs++;
      if (stall === 1'b1) stalls++;
      tick();
    end
    mif.mem_done = 0;
    tests++; if (reqs !== 1) begin fails++; $display("FAIL load_req_count got=%0d exp=1", reqs); end
    tests++; if (stalls !== 3) begin fails++; $display("FAIL load_stall_cycles got=%0d exp=3", stalls); end
    tests++; if (MemOut_MEMWB !== 16'hBEEF || WrR_MEMWB !== 3'd3 || RegWrite_MEMWB !== 1'b1 || MemtoReg_MEMWB !== 1'b1) begin
      fails++; $display("FAIL load_memwb got=%h/%0d/%0b%0b exp=beef/3/11", MemOut_MEMWB, WrR_MEMWB,
                        RegWrite_MEMWB, MemtoReg_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_store();
    int stalls = 0;
    clear_inputs();
    ALUO_EXMEM = 16'h0020; Rd2_EXMEM = 16'h1234; MemWrite_EXMEM = 1;
    #1;
    tests++; if (mif.mem_req !== 1'b1 || mif.mem_wr !== 1'b1 || mif.mem_wdata !== 16'h1234 || mif.mem_addr !== 16'h0020) begin
      fails++; $display("FAIL store_req got=%0h/%0h/%h/%h exp=1/1/1234/0020", mif.mem_req, mif.mem_wr,
                        mif.mem_wdata, mif.mem_addr); end
    if (stall === 1'b1) stalls++;
    tick();
    mif.mem_done = 1; mif.mem_rdata = 16'hAAAA;
    #1;
    if (stall === 1'b1) stalls++;
    tests++; if (mif.mem_wr !== 1'b1) begin fails++; $display("FAIL store_busy_wr got=%0h exp=1", mif.mem_wr); end
    tick();
    mif.mem_done = 0;
    tests++; if (stalls !== 1) begin fails++; $display("FAIL store_stall_cycles got=%0d exp=1", stalls); end
    tests++; if (MemOut_MEMWB !== 16'h0 || RegWrite_MEMWB !== 1'b0 || ALUO_MEMWB !== 16'h0020) begin
      fails++; $display("FAIL store_memwb got=%h/%0b/%h exp=0000/0/0020", MemOut_MEMWB, RegWrite_MEMWB, ALUO_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_misaligned();
    int bad = 0;
    clear_inputs();
    ALUO_EXMEM = 16'h0011; MemRead_EXMEM = 1; RegWrite_EXMEM = 1;
    #1;
    tests++; if (mif.mem_req !== 1'b0) begin fails++; $display("FAIL mis_req got=%0h exp=0", mif.mem_req); end
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err got=%0h exp=1", err); end
    for (int c = 0; c < 6; c++) begin
      ALUO_EXMEM = 16'($urandom); MemRead_EXMEM = 1'($urandom); RegWrite_EXMEM = 1;
      mif.mem_done = 1'($urandom);
      #1;
      if (stall !== 1'b1 || mif.mem_req !== 1'b0 || err !== 1'b1) bad++;
      tick();
      if (RegWrite_MEMWB !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL mis_hold got=%0d bad cycles exp=0", bad); end
    do_reset();
    #1;
    tests++; if (err !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mis_reset got err=%0h stall=%0h exp=0/0", err, stall); end
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int early = 0;
    clear_inputs();
    ALUO_EXMEM = 16'h0040; MemRead_EXMEM = 1; RegWrite_EXMEM = 1;
    #1;
    if (mif.mem_req === 1'b1) reqs++;
    tick();
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (mif.mem_req === 1'b1) reqs++;
      if (err !== 1'b0 || stall !== 1'b1) early++;
      tick();
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL to_early got=%0d bad cycles exp=0", early); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err got=%0h exp=1", err); end
    tests++; if (reqs !== 1) begin fails++; $display("FAIL to_req_count got=%0d exp=1", reqs); end
    do_reset();
  endtask

  task automatic test_non_mem();
    clear_inputs();
    ALUO_EXMEM = 16'h00FF; RegWrite_EXMEM = 1; WrR_EXMEM = 3'd5;
    #1;
    tests++; if (stall !== 1'b0 || mif.mem_req !== 1'b0) begin
      fails++; $display("FAIL nm_stall got=%0h req=%0h exp=0/0", stall, mif.mem_req); end
    tick();
    tests++; if (ALUO_MEMWB !== 16'h00FF || MemOut_MEMWB !== 16'h0 || WrR_MEMWB !== 3'd5 || RegWrite_MEMWB !== 1'b1) begin
      fails++; $display("FAIL nm_memwb got=%h/%h/%0d/%0b exp=00ff/0000/5/1", ALUO_MEMWB, MemOut_MEMWB,
                        WrR_MEMWB, RegWrite_MEMWB); end
    clear_inputs();
  endtask

  task automatic test_reset_in_busy();
    clear_inputs();
    ALUO_EXMEM = 16'h0030; MemRead_EXMEM = 1; RegWrite_EXMEM = 1; WrR_EXMEM = 3'd6;
    tick();
    rst = 0;
    tick();
    clear_inputs();
    rst = 1;
    mif.mem_done = 1; mif.mem_rdata = 16'h5555;
    #1;
    tests++; if (stall !== 1'b0 || mif.mem_req !== 1'b0 || err !== 1'b0 || mif.mem_addr !== 16'h0) begin
      fails++; $display("FAIL rib_outputs got stall=%0h req=%0h err=%0h addr=%h exp=0/0/0/0000",
                        stall, mif.mem_req, err, mif.mem_addr); end
    tick();
    mif.mem_done = 0;
    tests++; if (MemOut_MEMWB !== 16'h0 || RegWrite_MEMWB !== 1'b0 || ALUO_MEMWB !== 16'h0 || WrR_MEMWB !== 3'd0) begin
      fails++; $display("FAIL rib_memwb got=%h/%0b/%h/%0d exp=0000/0/0000/0", MemOut_MEMWB, RegWrite_MEMWB,
                        ALUO_MEMWB, WrR_MEMWB); end
  endtask

  // Back-to-back random instructions; each access takes 1..4 cycles to complete.
  task automatic test_random();
    logic [15:0] prev_aluo;
    logic [15:0] exp_out;
    logic [15:0] rd;
    int kind, lat;
    do_reset();
    prev_aluo = '0;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      ALUO_EXMEM       = (kind == 0) ? 16'($urandom) : (16'($urandom) & 16'hFFFE);
      Rd2_EXMEM        = 16'($urandom);
      WrR_EXMEM        = 3'($urandom);
      RegWrite_EXMEM   = 1'($urandom);
      MemtoReg_EXMEM   = 1'($urandom);
      Dump_EXMEM       = 1'($urandom);
      MemRead_EXMEM    = (kind == 1);
      MemWrite_EXMEM   = (kind == 2);
      takeBranch_EXMEM = 1'($urandom);
      PCS_EXMEM        = 16'($urandom);
      mif.mem_done     = 1'($urandom);
      #1;
      tests++; if (takeBranch_out !== takeBranch_EXMEM || PCS_out !== PCS_EXMEM) begin
        fails++; $display("FAIL rnd_branch n=%0d got=%0b/%h exp=%0b/%h", n, takeBranch_out, PCS_out,
                          takeBranch_EXMEM, PCS_EXMEM); end
      exp_out = 16'h0;
      if (kind == 0) begin
        tests++; if (stall !== 1'b0 || mif.mem_req !== 1'b0) begin
          fails++; $display("FAIL rnd_nm_stall n=%0d got=%0h/%0h exp=0/0", n, stall, mif.mem_req); end
        tick();
      end else begin
        tests++; if (mif.mem_req !== 1'b1 || stall !== 1'b1 || mif.mem_addr !== ALUO_EXMEM ||
                     mif.mem_wr !== (kind == 2) || mif.mem_wdata !== Rd2_EXMEM) begin
          fails++; $display("FAIL rnd_req n=%0d got=%0h/%0h/%h/%0h/%h exp=1/1/%h/%0h/%h", n, mif.mem_req, stall,
                            mif.mem_addr, mif.mem_wr, mif.mem_wdata, ALUO_EXMEM, (kind == 2), Rd2_EXMEM); end
        lat = int'($urandom_range(1, 4));
        mif.mem_done = 0;
        tick();
        tests++; if (RegWrite_MEMWB !== 1'b0 || Dump_MEMWB !== 1'b0 || ALUO_MEMWB !== prev_aluo) begin
          fails++; $display("FAIL rnd_bubble n=%0d got=%0b/%0b/%h exp=0/0/%h", n, RegWrite_MEMWB, Dump_MEMWB,
                            ALUO_MEMWB, prev_aluo); end
        for (int c = 1; c < lat; c++) begin
          #1;
          tests++; if (stall !== 1'b1 || mif.mem_req !== 1'b0 || mif.mem_addr !== ALUO_EXMEM) begin
            fails++; $display("FAIL rnd_wait n=%0d got=%0h/%0h/%h exp=1/0/%h", n, stall, mif.mem_req,
                              mif.mem_addr, ALUO_EXMEM); end
          tick();
        end
        rd = 16'($urandom);
        mif.mem_done = 1; mif.mem_rdata = rd;
        #1;
        tests++; if (stall !== 1'b0 || mif.mem_req !== 1'b0) begin
          fails++; $display("FAIL rnd_done n=%0d got=%0h/%0h exp=0/0", n, stall, mif.mem_req); end
        if (kind == 1) exp_out = rd;
        tick();
        mif.mem_done = 0;
      end
      tests++; if (ALUO_MEMWB !== ALUO_EXMEM || MemOut_MEMWB !== exp_out || WrR_MEMWB !== WrR_EXMEM ||
                   RegWrite_MEMWB !== RegWrite_EXMEM || MemtoReg_MEMWB !== MemtoReg_EXMEM ||
                   Dump_MEMWB !== Dump_EXMEM) begin
        fails++; $display("FAIL rnd_memwb n=%0d got=%h/%h/%0d/%0b%0b%0b exp=%h/%h/%0d/%0b%0b%0b", n,
                          ALUO_MEMWB, MemOut_MEMWB, WrR_MEMWB, RegWrite_MEMWB, MemtoReg_MEMWB, Dump_MEMWB,
                          ALUO_EXMEM, exp_out, WrR_EXMEM, RegWrite_EXMEM, MemtoReg_EXMEM, Dump_EXMEM); end
      prev_aluo = ALUO_EXMEM;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_load();
    test_store();
    test_non_mem();
    test_misaligned();
    test_timeout();
    test_reset_in_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
